// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline stages and the hazard controller.
// The pipeline side uses the master modport; the controller uses slave.
interface pipeline_hazard_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic [4:0]       i_id_rs1;
   logic [4:0]       i_id_rs2;
   logic             i_id_use_rs1;
   logic             i_id_use_rs2;
   logic             i_ex_valid;
   logic             i_ex_is_load;
   logic [4:0]       i_ex_rd;
   logic             i_ex_branch_valid;
   logic             i_ex_taken;
   logic             i_ex_prediction;
   logic [XLEN-1:0]  i_ex_target;
   logic [XLEN-1:0]  i_ex_pc_plus4;
   logic             i_mem_req;
   logic             i_mem_ready;
   logic             o_stall_if;
   logic             o_stall_id;
   logic             o_stall_ex;
   logic             o_stall_mem;
   logic             o_bubble_ex;
   logic             o_flush_if_id;
   logic             o_redirect;
   logic [XLEN-1:0]  o_redirect_pc;
   logic             o_mem_timeout;
   logic [CNT_W-1:0] o_mispredict_cnt;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [1:0]       o_state;

   modport master (
      output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
      output i_ex_valid, i_ex_is_load, i_ex_rd,
      output i_ex_branch_valid, i_ex_taken, i_ex_prediction, i_ex_target, i_ex_pc_plus4,
      output i_mem_req, i_mem_ready,
      input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
      input  o_bubble_ex, o_flush_if_id, o_redirect, o_redirect_pc,
      input  o_mem_timeout, o_mispredict_cnt, o_stall_cnt, o_state
   );

   modport slave (
      input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
      input  i_ex_valid, i_ex_is_load, i_ex_rd,
      input  i_ex_branch_valid, i_ex_taken, i_ex_prediction, i_ex_target, i_ex_pc_plus4,
      input  i_mem_req, i_mem_ready,
      output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
      output o_bubble_ex, o_flush_if_id, o_redirect, o_redirect_pc,
      output o_mem_timeout, o_mispredict_cnt, o_stall_cnt, o_state
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use interlock,
// mispredict redirect, data-memory wait with timeout, and perf counters.
module pipeline_hazard_ctrl #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  mis_cnt_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic mem_stall;
   logic mispredict_raw;
   logic load_use;
   logic wait_stall;
   logic eval_run;
   logic mis_inc;

   logic            stall_if, stall_id, stall_ex, stall_mem;
   logic            bubble_ex, flush_if_id, redirect;
   logic [XLEN-1:0] redirect_pc_out;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign mem_stall      = bus.i_mem_req & ~bus.i_mem_ready & ~timeout_q;
   assign mispredict_raw = bus.i_ex_branch_valid & (bus.i_ex_taken != bus.i_ex_prediction);
   assign load_use       = bus.i_ex_valid & bus.i_ex_is_load & (bus.i_ex_rd != 5'd0) &
                           ((bus.i_id_use_rs1 & (bus.i_id_rs1 == bus.i_ex_rd)) |
                            (bus.i_id_use_rs2 & (bus.i_id_rs2 == bus.i_ex_rd)));
   assign wait_stall     = mem_stall & (wait_cnt_q < WAIT_W'(MEM_TIMEOUT));

   // Combinational decode: stall/bubble/flush act in the same cycle as the hazard.
   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      redirect_pc_d   = redirect_pc_q;
      timeout_d       = timeout_q;
      mis_inc         = 1'b0;
      eval_run        = 1'b0;
      stall_if        = 1'b0;
      stall_id        = 1'b0;
      stall_ex        = 1'b0;
      stall_mem       = 1'b0;
      bubble_ex       = 1'b0;
      flush_if_id     = 1'b0;
      redirect        = 1'b0;
      redirect_pc_out = '0;

      case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               eval_run = 1'b1;
            end
         end
         ST_REDIRECT: begin
            // Redirect overrides fetch stall, so only ID/EX/MEM freeze here.
            redirect        = 1'b1;
            flush_if_id     = 1'b1;
            redirect_pc_out = redirect_pc_q;
            if (mem_stall) begin
               {stall_id, stall_ex, stall_mem} = 3'b111;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (wait_stall) begin
               {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
               state_d = ST_RUN;
               if (mem_stall) begin
                  timeout_d = 1'b1;
               end else begin
                  eval_run = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (eval_run) begin
         if (mispredict_raw) begin
            flush_if_id   = 1'b1;
            bubble_ex     = 1'b1;
            redirect_pc_d = bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc_plus4;
            mis_inc       = 1'b1;
            state_d       = ST_REDIRECT;
         end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         redirect_pc_q <= '0;
         timeout_q     <= 1'b0;
         mis_cnt_q     <= '0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         redirect_pc_q <= redirect_pc_d;
         timeout_q     <= timeout_d;
         if (mis_inc) mis_cnt_q <= sat_inc(mis_cnt_q);
         if (stall_if) stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign bus.o_stall_if       = stall_if;
   assign bus.o_stall_id       = stall_id;
   assign bus.o_stall_ex       = stall_ex;
   assign bus.o_stall_mem      = stall_mem;
   assign bus.o_bubble_ex      = bubble_ex;
   assign bus.o_flush_if_id    = flush_if_id;
   assign bus.o_redirect       = redirect;
   assign bus.o_redirect_pc    = redirect_pc_out;
   assign bus.o_mem_timeout    = timeout_q;
   assign bus.o_mispredict_cnt = mis_cnt_q;
   assign bus.o_stall_cnt      = stall_cnt_q;
   assign bus.o_state          = state_q;

endmodule
